// File: rtl/nes_joypad_pkg.sv
// Shared bit-index constants for USB-side and NES-side button vectors, plus the
// USB-to-NES remap used by the joypad port.
package nes_joypad_pkg;

  localparam int JP_A      = 0;
  localparam int JP_B      = 1;
  localparam int JP_SELECT = 2;
  localparam int JP_START  = 3;
  localparam int JP_UP     = 4;
  localparam int JP_DOWN   = 5;
  localparam int JP_LEFT   = 6;
  localparam int JP_RIGHT  = 7;

  localparam int UKP_A      = 0;
  localparam int UKP_B      = 1;
  localparam int UKP_SELECT = 2;
  localparam int UKP_START  = 3;
  localparam int UKP_LEFT   = 4;
  localparam int UKP_RIGHT  = 5;
  localparam int UKP_DOWN   = 6;
  localparam int UKP_UP     = 7;

  function automatic logic [7:0] remap_ukp2nes(input logic [7:0] u);
    logic [7:0] r;
    r           = '0;
    r[JP_A]      = u[UKP_A];
    r[JP_B]      = u[UKP_B];
    r[JP_SELECT] = u[UKP_SELECT];
    r[JP_START]  = u[UKP_START];
    r[JP_UP]     = u[UKP_UP];
    r[JP_DOWN]   = u[UKP_DOWN];
    r[JP_LEFT]   = u[UKP_LEFT];
    r[JP_RIGHT]  = u[UKP_RIGHT];
    return r;
  endfunction

endpackage

// File: rtl/nes_joypad_port_if.sv
// Bus bundle between the USB gamepad front end / CPU bus and the joypad port.
interface nes_joypad_port_if;
  logic [7:0] btn_in;
  logic       conerr_in;
  logic       cpu_wr;
  logic       cpu_wdata0;
  logic       cpu_rd;
  logic       joy_dout;
  logic [7:0] btn_state;
  logic       strobe;

  modport master (
    output btn_in, conerr_in, cpu_wr, cpu_wdata0, cpu_rd,
    input  joy_dout, btn_state, strobe
  );

  modport slave (
    input  btn_in, conerr_in, cpu_wr, cpu_wdata0, cpu_rd,
    output joy_dout, btn_state, strobe
  );
endinterface

// File: rtl/joypad_sync_filter.sv
// Synchronises the USB-domain button vector and error flag into clk, then
// accepts a button change only after STABLE_CYC identical samples.
module joypad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_btn,
  input  logic       i_err,
  output logic [7:0] o_btn_filt,
  output logic       o_err_sync
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0][7:0] r_sync_btn;
  logic [SYNC_STAGES-1:0]      r_sync_err;
  logic [7:0]                  r_cand;
  logic [CNT_W-1:0]            r_cnt;
  logic [7:0]                  r_filt;
  logic                        r_err;
  logic [7:0]                  w_s_btn;
  logic                        w_s_err;

  assign w_s_btn = r_sync_btn[SYNC_STAGES-1];
  assign w_s_err = r_sync_err[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_btn <= '0;
      r_sync_err <= '0;
    end else begin
      r_sync_btn <= {r_sync_btn[SYNC_STAGES-2:0], i_btn};
      r_sync_err <= {r_sync_err[SYNC_STAGES-2:0], i_err};
    end
  end

  // Connection error overrides the filter; r_err is aligned with r_filt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_filt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_s_err;
      if (w_s_err) begin
        r_cand <= '0;
        r_cnt  <= '0;
        r_filt <= '0;
      end else if (w_s_btn != r_cand) begin
        r_cand <= w_s_btn;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_btn_filt = r_filt;
  assign o_err_sync = r_err;

endmodule

// File: rtl/nes_joypad_port.sv
// NES 4021-style controller port for $4016/$4017 reads.
// Optional SOCD cleaning of opposing directions: define JOYPAD_SOCD_EN.
module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 16
) (
  input logic               clk,
  input logic               reset,
  nes_joypad_port_if.slave  bus
);

  logic [7:0] w_btn_filt;
  logic       w_err_sync;
  logic [7:0] w_btn_state;
  logic [7:0] w_pad;
  logic       r_strobe;
  logic [7:0] r_sr;

  joypad_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE_CYC  (STABLE_CYC)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .i_btn      (bus.btn_in),
    .i_err      (bus.conerr_in),
    .o_btn_filt (w_btn_filt),
    .o_err_sync (w_err_sync)
  );

  // The filter already clears on error; the mask keeps the state clean by construction.
  assign w_btn_state = w_err_sync ? 8'h00 : remap_ukp2nes(w_btn_filt);

`ifdef JOYPAD_SOCD_EN
  always_comb begin
    w_pad = w_btn_state;
    if (w_btn_state[JP_UP] && w_btn_state[JP_DOWN]) begin
      w_pad[JP_UP]   = 1'b0;
      w_pad[JP_DOWN] = 1'b0;
    end
    if (w_btn_state[JP_LEFT] && w_btn_state[JP_RIGHT]) begin
      w_pad[JP_LEFT]  = 1'b0;
      w_pad[JP_RIGHT] = 1'b0;
    end
  end
`else
  assign w_pad = w_btn_state;
`endif

  // Shift decisions use the pre-edge strobe, so a 1->0 write still captures pad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe <= 1'b0;
      r_sr     <= 8'h00;
    end else begin
      if (bus.cpu_wr) r_strobe <= bus.cpu_wdata0;
      if (r_strobe) begin
        r_sr <= w_pad;
      end else if (bus.cpu_rd) begin
        r_sr <= {1'b1, r_sr[7:1]};
      end
    end
  end

  assign bus.joy_dout  = r_strobe ? w_pad[0] : r_sr[0];
  assign bus.btn_state = w_btn_state;
  assign bus.strobe    = r_strobe;

endmodule

// File: doc/nes_joypad_port.md
# nes_joypad_port

Emulates the NES controller's 4021 parallel-to-serial shift register for the CPU's $4016/$4017 read path. Consumes the 8-bit button vector and connection-error flag from the USB gamepad front end (`ukp2nes`, 12 MHz USB domain) and presents them to the NES core in the system clock domain. Provides:
- synchronisation of the USB-side inputs,
- stability filtering of the button vector,
- bit remapping to NES shift order,
- strobe/latch and serial-read semantics.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages per input bit; legal range 2–3.
- `STABLE_CYC`, default 16: consecutive identical synchronised samples required before a button change is accepted; legal range 2–255.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_in` in 8: button vector from the USB domain; asynchronous to `clk`. Bit map: 0=A, 1=B, 2=Select, 3=Start, 4=Left, 5=Right, 6=Down, 7=Up; 1=pressed.
- `conerr_in` in 1: USB connection error; asynchronous to `clk`.
- `cpu_wr` in 1: one-cycle pulse for a CPU write to $4016.
- `cpu_wdata0` in 1: bit 0 of the CPU write data; the strobe value.
- `cpu_rd` in 1: one-cycle pulse for a CPU read of this port.
- `joy_dout` out 1: serial data bit for the current read; 1=pressed.
- `btn_state` out 8: filtered buttons in NES order. Bit map: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- `strobe` out 1: current strobe latch.

## Operation
**Synchronisers.** `btn_in` and `conerr_in` each pass through `SYNC_STAGES` flops, producing `s_btn` and `s_err`.

**Stability filter.** Registers: `cand[7:0]` and `cnt`, with width clog2(`STABLE_CYC`).
- If `s_err` = 1: `cand`←0, `cnt`←0, `btn_state`←0. This takes priority over everything below.
- Else if `s_btn` ≠ `cand`: `cand`←`s_btn`, `cnt`←0.
- Else if `cnt` = `STABLE_CYC`−1: `btn_state`←remap(`cand`); `cnt` holds.
- Else: `cnt`←`cnt`+1.

**Remap.** NES order is {Right, Left, Down, Up, Start, Select, B, A} (bit 7 down to bit 0), taken from `cand` bits {5, 4, 6, 7, 3, 2, 1, 0}.

**Strobe.** On `cpu_wr`, `strobe`←`cpu_wdata0`.

**Shift register `sr[7:0]`**, evaluated against the pre-edge value of `strobe`:
- If `strobe` = 1: `sr`←`pad` every cycle, where `pad` is `btn_state` after the optional SOCD stage. A `cpu_rd` in this state causes no shift.
- Else if `cpu_rd`: `sr`←{1'b1, `sr[7:1]`}. After 8 reads, every further read returns 1.
- Else: `sr` holds.

**Output.** `joy_dout` is combinational: `strobe` ? `pad[0]` : `sr[0]`. It is valid in the same cycle as `cpu_rd`.

**Boundary cases.**
- `cpu_wr` and `cpu_rd` in the same cycle: the read returns data and shifts according to the old `strobe`. The write takes effect at the same edge.
- A 1→0 strobe write: `sr` captures `pad` at that edge, because the old strobe was 1.
- Inputs changing mid-read (`strobe` = 0): `sr` is unaffected. The new value becomes visible only after the next strobe.
- A glitch shorter than `STABLE_CYC` synchronised cycles is never reflected in `btn_state`.

## Timing
- Reset values: `btn_state`=0, `strobe`=0, `sr`=8'h00, `joy_dout`=0, `cand`=0, `cnt`=0, all sync flops 0.
- `btn_in` step to `btn_state` update: edge number `SYNC_STAGES`+1+`STABLE_CYC` after the change, if the input is held stable. Default value: 19 cycles.
- `conerr_in` rise to `btn_state`=0: edge `SYNC_STAGES`+1.
- `conerr_in` fall: normal filter latency from that point.
- `cpu_wr` to `strobe`: 1 edge.
- `cpu_rd` to `joy_dout`: 0 cycles, combinational.
- Shift: occurs on the edge that ends the `cpu_rd` cycle.
- Back-to-back `cpu_rd` pulses on consecutive cycles are legal and each one shifts.

## Configuration
- `JOYPAD_SOCD_EN` defined: the SOCD cleaner is compiled in. It works on `btn_state`.
  - Up+Down both set → both cleared in `pad`.
  - Left+Right both set → both cleared in `pad`.
  - `btn_state` itself still shows the raw filtered value.
- `JOYPAD_SOCD_EN` undefined: `pad` = `btn_state` and opposing directions pass through unchanged.

## Structure
- Shared package `nes_joypad_pkg` holds:
  - NES bit-index constants (`JP_A`…`JP_RIGHT`),
  - USB-side bit-index constants (`UKP_A`…`UKP_UP`),
  - the remap function.
- Sub-module `joypad_sync_filter` contains the synchronisers and stability filter. Its outputs are `btn_filt[7:0]` (USB order) and `err_sync`.
- The top level holds the remap, SOCD stage, strobe and shift register.

## Test plan
- **Reset and latency:** assert `reset`, release, hold `btn_in`=8'h01 → `btn_state`=8'h01 exactly at edge 19. Before that edge, `joy_dout`=0 and `strobe`=0.
- **Glitch rejection:** pulse `btn_in` to 8'h80 for 10 cycles, then return to 0 → `btn_state` stays 0. Hold 8'h80 for 30 cycles → `btn_state`=8'h10 (Up).
- **Serial read:** `btn_in`=8'h29 (A, Start, Right), settle, write strobe 1 then 0, then 10 `cpu_rd` pulses → `joy_dout` sequence 1,0,0,1,0,0,0,1,1,1.
- **Strobe high:** with A pressed, strobe=1, 3 reads → `joy_dout`=1 each time. Then strobe 0 and read → 1, then the next read returns B=0.
- **Connection error:** buttons 8'hFF settled, raise `conerr_in` → `btn_state`=0 at edge 3. Strobe/read then returns eight 0s followed by 1s.
- **SOCD, `JOYPAD_SOCD_EN` defined:** `btn_in`=8'hF0 → `btn_state`=8'hF0, and a serial read returns 0 for bits 4–7. With the macro undefined → bits 4–7 read 1.
